// File: rtl/cond_branch_unit_pkg.sv
// Shared constants for the branch resolve stage: condition codes, flag bit positions, FSM states.
// Flag vector bit order is {C,L,F,Z,N} = [4:0].
package cond_branch_unit_pkg;

    localparam int unsigned FLAG_W = 5;
    localparam int unsigned COND_W = 4;

    localparam logic [COND_W-1:0] COND_EQ = 4'h0;
    localparam logic [COND_W-1:0] COND_NE = 4'h1;
    localparam logic [COND_W-1:0] COND_CS = 4'h2;
    localparam logic [COND_W-1:0] COND_CC = 4'h3;
    localparam logic [COND_W-1:0] COND_HI = 4'h4;
    localparam logic [COND_W-1:0] COND_LS = 4'h5;
    localparam logic [COND_W-1:0] COND_GT = 4'h6;
    localparam logic [COND_W-1:0] COND_LE = 4'h7;
    localparam logic [COND_W-1:0] COND_FS = 4'h8;
    localparam logic [COND_W-1:0] COND_FC = 4'h9;
    localparam logic [COND_W-1:0] COND_LO = 4'hA;
    localparam logic [COND_W-1:0] COND_HS = 4'hB;
    localparam logic [COND_W-1:0] COND_LT = 4'hC;
    localparam logic [COND_W-1:0] COND_GE = 4'hD;
    localparam logic [COND_W-1:0] COND_UC = 4'hE;
    localparam logic [COND_W-1:0] COND_NV = 4'hF;

    localparam int unsigned FLAG_N = 0;
    localparam int unsigned FLAG_Z = 1;
    localparam int unsigned FLAG_F = 2;
    localparam int unsigned FLAG_L = 3;
    localparam int unsigned FLAG_C = 4;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

endpackage

// File: rtl/cond_branch_unit_cond_eval.sv
// Combinational condition evaluator: {flags, cond} -> taken.
// Kept standalone so predicated-op logic can reuse it.
module cond_branch_unit_cond_eval
    import cond_branch_unit_pkg::*;
(
    input  logic [FLAG_W-1:0] flags_i,
    input  logic [COND_W-1:0] cond_i,
    output logic              taken_o
);

    logic c_f, l_f, f_f, z_f, n_f;

    assign c_f = flags_i[FLAG_C];
    assign l_f = flags_i[FLAG_L];
    assign f_f = flags_i[FLAG_F];
    assign z_f = flags_i[FLAG_Z];
    assign n_f = flags_i[FLAG_N];

    always_comb begin
        taken_o = 1'b0;
        case (cond_i)
            COND_EQ: taken_o = z_f;
            COND_NE: taken_o = ~z_f;
            COND_CS: taken_o = c_f;
            COND_CC: taken_o = ~c_f;
            COND_HI: taken_o = l_f;
            COND_LS: taken_o = ~l_f;
            COND_GT: taken_o = n_f;
            COND_LE: taken_o = ~n_f;
            COND_FS: taken_o = f_f;
            COND_FC: taken_o = ~f_f;
            COND_LO: taken_o = ~l_f & ~z_f;
            COND_HS: taken_o = l_f | z_f;
            COND_LT: taken_o = ~n_f & ~z_f;
            COND_GE: taken_o = n_f | z_f;
            COND_UC: taken_o = 1'b1;
            COND_NV: taken_o = 1'b0;
            default: taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_branch_unit.sv
// Branch/jump resolve stage: single-entry valid/ready pipeline returning taken + next PC to fetch.
// Optional FLAG_BYPASS_EN adds flag_wr_en/flag_next to evaluate in-flight flags without a bubble.
module cond_branch_unit
    import cond_branch_unit_pkg::*;
#(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DISP_W = 8
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              flush,
    input  logic [FLAG_W-1:0] savedFlags,
`ifdef FLAG_BYPASS_EN
    input  logic              flag_wr_en,
    input  logic [FLAG_W-1:0] flag_next,
`endif
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [COND_W-1:0] req_cond,
    input  logic              req_is_jump,
    input  logic [ADDR_W-1:0] req_pc,
    input  logic [DISP_W-1:0] req_disp,
    input  logic [ADDR_W-1:0] req_reg_tgt,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              res_taken,
    output logic [ADDR_W-1:0] res_pc
);

    localparam int unsigned EXT_W = ADDR_W - DISP_W;

    logic [0:0]        state_q, state_d;
    logic              res_taken_q, res_taken_d;
    logic [ADDR_W-1:0] res_pc_q, res_pc_d;
    logic [FLAG_W-1:0] eval_flags;
    logic              cond_true;
    logic              accept;
    logic [ADDR_W-1:0] br_tgt, seq_pc;

`ifdef FLAG_BYPASS_EN
    // Flags being written this cycle are newer than the flag register contents.
    assign eval_flags = flag_wr_en ? flag_next : savedFlags;
`else
    assign eval_flags = savedFlags;
`endif

    cond_branch_unit_cond_eval u_cond_eval (
        .flags_i (eval_flags),
        .cond_i  (req_cond),
        .taken_o (cond_true)
    );

    assign br_tgt = req_pc + {{EXT_W{req_disp[DISP_W-1]}}, req_disp};
    assign seq_pc = req_pc + ADDR_W'(1);

    assign req_ready = (state_q == ST_IDLE) | res_ready;
    assign accept    = req_valid & req_ready & ~flush;

    // Next state and result payload; flush wins over a same-cycle accept.
    always_comb begin
        state_d     = state_q;
        res_taken_d = res_taken_q;
        res_pc_d    = res_pc_q;
        if (flush) begin
            state_d = ST_IDLE;
        end else if (accept) begin
            state_d     = ST_HOLD;
            res_taken_d = cond_true;
            if (!cond_true) begin
                res_pc_d = seq_pc;
            end else if (req_is_jump) begin
                res_pc_d = req_reg_tgt;
            end else begin
                res_pc_d = br_tgt;
            end
        end else if ((state_q == ST_HOLD) && res_ready) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= ST_IDLE;
            res_taken_q <= 1'b0;
            res_pc_q    <= '0;
        end else begin
            state_q     <= state_d;
            res_taken_q <= res_taken_d;
            res_pc_q    <= res_pc_d;
        end
    end

    assign res_valid = (state_q == ST_HOLD);
    assign res_taken = res_taken_q;
    assign res_pc    = res_pc_q;

endmodule
